// File: rtl/instr_mem_pkg.sv
// Shared constants for the instruction/data memory controllers: default widths,
// the NOP word and the controller state encoding.
package instr_mem_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 10;

   localparam logic [DEF_DATA_WIDTH-1:0] DEF_NOP = '0;

   typedef logic [1:0] state_t;

   localparam state_t ST_CLEAR = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_PROG  = 2'd2;

endpackage

// File: rtl/instr_mem_ram.sv
// Single-port synchronous RAM: read-first, registered read data, one access per cycle.
module instr_mem_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // NOTE: the array has no reset so it maps onto block RAM; the controller's
   // CLEAR pass is what gives it defined contents.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
      r_rdata <= r_mem[addr];
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: clears the RAM to NOP after reset, then serves
// 1-cycle fetches with stall hold and accepts run-time program writes.
module instr_mem_ctrl
   import instr_mem_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    DEPTH      = 1024,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DEF_NOP
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_en,
   input  logic                  stall,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  addr_err,
   input  logic                  prog_en,
   input  logic                  prog_we,
   input  logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   output logic                  prog_ack,
   output logic                  ready
);

   localparam int                    RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_CMP = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_clr_ptr;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic                  r_fresh;
   logic                  r_valid;
   logic                  r_err;
   logic                  r_ack;

   logic                  w_fetch_ok;
   logic                  w_prog_ok;
   logic                  w_ram_we;
   logic [RAM_AW-1:0]     w_ram_addr;
   logic [DATA_WIDTH-1:0] w_ram_wdata;
   logic [DATA_WIDTH-1:0] w_ram_rdata;
   logic [DATA_WIDTH-1:0] w_data_out;

   assign w_fetch_ok = {1'b0, address}   < DEPTH_CMP;
   assign w_prog_ok  = {1'b0, prog_addr} < DEPTH_CMP;

   // The single RAM port is owned by whichever state is active.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_ram_we    = 1'b0;
      w_ram_addr  = '0;
      w_ram_wdata = NOP_WORD;
      case (r_state)
         ST_CLEAR: begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_clr_ptr[RAM_AW-1:0];
         end
         ST_RUN: begin
            if (w_fetch_ok) w_ram_addr = address[RAM_AW-1:0];
         end
         ST_PROG: begin
            w_ram_we    = prog_we && w_prog_ok;
            w_ram_wdata = prog_data;
            if (w_prog_ok) w_ram_addr = prog_addr[RAM_AW-1:0];
         end
         default: ;
      endcase
   end

   instr_mem_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (RAM_AW),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (w_ram_we),
      .addr  (w_ram_addr),
      .wdata (w_ram_wdata),
      .rdata (w_ram_rdata)
   );

   // RAM read data is shown only the cycle after an in-range fetch; r_data_q
   // keeps whatever was last shown so stalls and idle cycles hold it.
   assign w_data_out = r_fresh ? w_ram_rdata : r_data_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_CLEAR;
         r_clr_ptr <= '0;
         r_data_q  <= NOP_WORD;
         r_fresh   <= 1'b0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         r_fresh  <= 1'b0;
         r_ack    <= 1'b0;
         r_data_q <= w_data_out;
         case (r_state)
            ST_CLEAR: begin
               if (r_clr_ptr == LAST_IDX) begin
                  r_clr_ptr <= '0;
                  r_state   <= ST_RUN;
               end else begin
                  r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
               end
            end
            ST_RUN: begin
               if (prog_en) begin
                  r_state <= ST_PROG;
                  r_valid <= 1'b0;
                  r_err   <= 1'b0;
               end else if (!stall) begin
                  r_valid <= fetch_en;
                  r_err   <= fetch_en && !w_fetch_ok;
                  r_fresh <= fetch_en && w_fetch_ok;
                  if (fetch_en && !w_fetch_ok) r_data_q <= NOP_WORD;
               end
            end
            ST_PROG: begin
               r_valid <= 1'b0;
               if (prog_we) begin
                  r_ack <= 1'b1;
                  r_err <= !w_prog_ok;
               end
               if (!prog_en) r_state <= ST_RUN;
            end
            default: r_state <= ST_CLEAR;
         endcase
      end
   end

   assign data_out   = w_data_out;
   assign data_valid = r_valid;
   assign addr_err   = r_err;
   assign prog_ack   = r_ack;
   assign ready      = (r_state == ST_RUN);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Randomized scoreboard bench for instr_mem_ctrl (DEPTH=16, ADDR_WIDTH=10, NOP=0).
module tb_instr_mem_ctrl;

   localparam int          DW    = 32;
   localparam int          AW    = 10;
   localparam int          DEPTH = 16;
   localparam logic [DW-1:0] NOP = 32'h0;

   localparam int M_CLEAR = 0;
   localparam int M_RUN   = 1;
   localparam int M_PROG  = 2;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
   } fetch_exp_t;

   logic          clk;
   logic          rst_n;
   logic          fetch_en;
   logic          stall;
   logic [AW-1:0] address;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          addr_err;
   logic          prog_en;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic          prog_ack;
   logic          ready;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_exp_t exp_q[$];
   logic       ack_q[$];

   logic [DW-1:0] model_mem [DEPTH];
   int            mode  = M_CLEAR;
   bit            mvalid = 1'b0;
   fetch_exp_t    last;

   fetch_exp_t mon_e;
   logic       mon_ack_err;

   instr_mem_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .NOP_WORD   (NOP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_en   (fetch_en),
      .stall      (stall),
      .address    (address),
      .data_out   (data_out),
      .data_valid (data_valid),
      .addr_err   (addr_err),
      .prog_en    (prog_en),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .prog_ack   (prog_ack),
      .ready      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents a result or an ack.
   initial begin
      forever begin
         @(negedge clk);
         if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected data_valid", data_valid, 1'b0);
            end else begin
               mon_e = exp_q.pop_front();
               check("fetch data_out", data_out, mon_e.data);
               check("fetch addr_err", addr_err, mon_e.err);
            end
         end
         if (prog_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
               check("unexpected prog_ack", prog_ack, 1'b0);
            end else begin
               mon_ack_err = ack_q.pop_front();
               check("prog_ack addr_err", addr_err, mon_ack_err);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // One clock of stimulus; the model predicts what the DUT must show next cycle.
   task automatic run_cycle(input bit fe, input bit st, input logic [AW-1:0] a,
                            input bit pe, input bit pw, input logic [AW-1:0] pa,
                            input logic [DW-1:0] pd);
      check("ready vs mode", ready, (mode == M_RUN));
      fetch_en  = fe;
      stall     = st;
      address   = a;
      prog_en   = pe;
      prog_we   = pw;
      prog_addr = pa;
      prog_data = pd;
      case (mode)
         M_RUN: begin
            if (pe) begin
               mode   = M_PROG;
               mvalid = 1'b0;
            end else if (st) begin
               if (mvalid) exp_q.push_back(last);
            end else if (fe) begin
               last.err  = (int'(a) >= DEPTH);
               last.data = last.err ? NOP : model_mem[int'(a)];
               mvalid    = 1'b1;
               exp_q.push_back(last);
            end else begin
               mvalid = 1'b0;
            end
         end
         M_PROG: begin
            if (pw) begin
               if (int'(pa) < DEPTH) model_mem[int'(pa)] = pd;
               ack_q.push_back(int'(pa) >= DEPTH);
            end
            if (!pe) mode = M_RUN;
            mvalid = 1'b0;
         end
         default: ;
      endcase
      @(negedge clk);
   endtask

   task automatic fetch(input logic [AW-1:0] a);
      run_cycle(1'b1, 1'b0, a, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic idle();
      run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic prog_write(input bit pe, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
      run_cycle(1'b0, 1'b0, '0, pe, 1'b1, pa, pd);
   endtask

   task automatic apply_reset();
      #2;
      rst_n     = 1'b0;
      fetch_en  = 1'b0;
      stall     = 1'b0;
      address   = '0;
      prog_en   = 1'b0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      #1;
      check("reset data_valid", data_valid, 1'b0);
      check("reset ready", ready, 1'b0);
      check("reset prog_ack", prog_ack, 1'b0);
      check("reset addr_err", addr_err, 1'b0);
      check("reset data_out", data_out, NOP);
      check("pending fetch results at reset", exp_q.size(), 0);
      check("pending acks at reset", ack_q.size(), 0);
      exp_q.delete();
      ack_q.delete();
      mode   = M_CLEAR;
      mvalid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Clear takes DEPTH cycles; ready must first be seen in cycle DEPTH+1.
   task automatic wait_clear();
      for (int c = 1; c <= DEPTH + 1; c++) begin
         @(negedge clk);
         check($sformatf("ready in clear cycle %0d", c), ready, (c == DEPTH + 1));
      end
      for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
      mode   = M_RUN;
      mvalid = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] ra;
      bit            rfe, rst_b, rpe, rpw;

      rst_n = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

      apply_reset();
      wait_clear();
      for (int i = 0; i < DEPTH; i++) fetch(AW'(i));
      idle();

      // prog_en wins over a same-cycle fetch.
      run_cycle(1'b1, 1'b0, AW'(5), 1'b1, 1'b0, '0, '0);
      check("priority data_valid", data_valid, 1'b0);
      check("priority ready", ready, 1'b0);
      prog_write(1'b1, AW'(0),  32'h0DE0_0A00);
      prog_write(1'b1, AW'(1),  32'h0DE1_0A01);
      prog_write(1'b1, AW'(20), 32'hDEAD_BEEF);
      prog_write(1'b0, AW'(7),  32'h00C0_FFEE);

      fetch(AW'(0));
      fetch(AW'(1));
      fetch(AW'(1));
      repeat (3) run_cycle(1'b1, 1'b1, AW'(0), 1'b0, 1'b0, '0, '0);
      fetch(AW'(0));
      fetch(AW'(20));
      fetch(AW'(4));
      fetch(AW'(7));
      fetch(AW'(1023));
      idle();
      idle();

      for (int n = 0; n < 500; n++) begin
         ra = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 1023))
                                          : AW'($urandom_range(0, DEPTH - 1));
         if (mode == M_RUN) begin
            rpe   = ($urandom_range(0, 15) == 0);
            rst_b = !rpe && ($urandom_range(0, 3) == 0);
            rfe   = ($urandom_range(0, 3) != 0);
            run_cycle(rfe, rst_b, ra, rpe, 1'b0, '0, '0);
         end else begin
            rpe = ($urandom_range(0, 5) != 0);
            rpw = ($urandom_range(0, 2) != 0);
            run_cycle(1'b0, 1'b0, '0, rpe, rpw, ra, DW'($urandom));
         end
      end
      idle();
      idle();

      // Reset in the middle of clear, then in the middle of a program burst.
      apply_reset();
      repeat (8) @(negedge clk);
      apply_reset();
      wait_clear();
      run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
      prog_write(1'b1, AW'(2), 32'h1234_5678);
      prog_write(1'b1, AW'(3), 32'h9ABC_DEF0);
      apply_reset();
      wait_clear();
      for (int i = 0; i < DEPTH; i++) fetch(AW'(i));
      idle();
      idle();

      check("fetch results left unconsumed", exp_q.size(), 0);
      check("acks left unconsumed", ack_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
